// File: rtl/muestreador_adc.sv
// -----------------------------------------------------------------------------
// muestreador_adc
// Serial ADC front end. Every SAMPLE_PERIOD clocks (while Enable=1) it reads one
// 16-bit frame (4 leading zeros + 12 data bits, MSB first) from an SPI-style
// ADC, removes the mid-scale offset and scales the code to W-bit two's
// complement for the derivative stage downstream.
//
// Ports
//   CLK           in   system clock, rising edge
//   Reset         in   asynchronous reset, active low
//   Enable        in   run control; 0 stops new conversions
//   sdata         in   ADC serial data
//   cs_n          out  ADC chip select, active low
//   sclk          out  ADC serial clock, idles high
//   y             out  sign_ext((code - 2048) <<< FRAC), holds between strobes
//   muestra_lista out  1-CLK strobe: y holds a new sample
//   frame_err     out  1-CLK strobe: leading zeros violated, y not updated
// -----------------------------------------------------------------------------
module muestreador_adc #(
    parameter int W             = 19,
    parameter int FRAC          = 6,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Enable,
    input  logic         sdata,
    output logic         cs_n,
    output logic         sclk,
    output logic [W-1:0] y,
    output logic         muestra_lista,
    output logic         frame_err
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [DW-1:0]   r_div;
    logic            r_phase;     // 0: sclk low half, 1: sclk high half
    logic [3:0]      r_bit;
    logic [15:0]     r_shift;
    logic [W-1:0]    r_y;

    logic            w_tick;
    logic            w_div_end;
    logic            w_sample;
    logic [15:0]     w_shift_next;
    logic            w_frame_ok;
    logic signed [12:0] w_diff;
    logic [W-1:0]    w_y_new;

    assign w_tick    = Enable && (r_timer == TW'(SAMPLE_PERIOD - 1));
    assign w_div_end = (r_div == DW'(CLK_DIV - 1));

    // sdata is taken at the end of the first clock of each sclk high half.
    assign w_sample     = (r_state == S_SHIFT) && r_phase && (r_div == '0);
    assign w_shift_next = w_sample ? {r_shift[14:0], sdata} : r_shift;

    // y is loaded on the edge entering DONE, from the frame as it will stand
    // after that edge, so the last bit is included even when CLK_DIV=1.
    assign w_diff  = $signed({1'b0, w_shift_next[11:0]}) - 13'sd2048;
    assign w_y_new = {{(W - 13){w_diff[12]}}, w_diff} << FRAC;

    assign w_frame_ok = (r_shift[15:12] == 4'd0);
    assign y          = r_y;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        cs_n          = 1'b1;
        sclk          = 1'b1;
        muestra_lista = 1'b0;
        frame_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) w_next = S_CS_SETUP;
            end
            S_CS_SETUP: begin
                cs_n = 1'b0;
                if (w_div_end) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                cs_n = 1'b0;
                sclk = r_phase;
                if (w_div_end && r_phase && (r_bit == 4'd15)) w_next = S_DONE;
            end
            S_DONE: begin
                muestra_lista = w_frame_ok;
                frame_err     = !w_frame_ok;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_timer <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
            r_y     <= '0;
        end else begin
            if (!Enable || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                S_CS_SETUP: begin
                    r_div <= w_div_end ? '0 : r_div + 1'b1;
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_phase <= ~r_phase;
                        if (r_phase) r_bit <= r_bit + 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_div   <= '0;
                    r_phase <= 1'b0;
                    r_bit   <= '0;
                end
            endcase

            r_shift <= w_shift_next;

            if ((w_next == S_DONE) && (r_state != S_DONE) &&
                (w_shift_next[15:12] == 4'd0)) begin
                r_y <= w_y_new;
            end
        end
    end

endmodule
